mem_bus_interconnect: RTL and testbench
=======================================

Name: mem_bus_interconnect

Overview:
Parametrised byte-bus interconnect between the CPU memory port and NUM_SLAVES memory-mapped targets (ROM, RAM, future peripherals). It replaces fixed combinational ROM/RAM range muxing with the following:
- a registered request/ready handshake
- per-slave variable latency via s_ready
- unmapped-address and timeout bus errors, with a sticky error-status register

It sits between cpu and all memories in the SoC top.

Parameters:
- ADDR_W, 32, master/slave address width
- DATA_W, 8, data width
- NUM_SLAVES, 2, number of target regions (1..8)
- SLAVE_BASE, {32'h0000_1000, 32'h0000_0000}, flattened bases; slave i at [i*ADDR_W +: ADDR_W]
- SLAVE_SIZE, {32'h0000_1000, 32'h0000_1000}, flattened region sizes in bytes, same packing
- TIMEOUT_CYCLES, 16, max ACCESS cycles before bus error; 0 disables timeout

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m_req  in  1  master request, sampled only in IDLE
- m_we  in  1  master write enable
- m_addr  in  ADDR_W  master absolute address
- m_wdata  in  DATA_W  master write data
- m_rdata  out  DATA_W  read data, valid when m_ready=1
- m_ready  out  1  one-cycle completion pulse
- m_err  out  1  bus error, qualifies m_ready
- s_sel  out  NUM_SLAVES  one-hot slave select
- s_we  out  1  slave write enable
- s_addr  out  ADDR_W  slave-relative offset (addr - base)
- s_wdata  out  DATA_W  slave write data
- s_rdata  in  NUM_SLAVES*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
- s_ready  in  NUM_SLAVES  slave completion
- err_valid  out  1  sticky error flag
- err_addr  out  ADDR_W  address of the most recent faulting access
- err_clear  in  1  clears err_valid

Behaviour:
- States: IDLE, ACCESS, RESP, ERR.
- Reset (sync, rst=1 at an edge):
  - state=IDLE; all outputs 0; err_valid=0; err_addr=0; wait counter 0.
  - Reset during ACCESS aborts the transfer: s_sel drops at that edge and no m_ready is issued.
- Decode: hit_i = (BASE_i <= m_addr) && (m_addr < BASE_i + SIZE_i), unsigned, ADDR_W+1-bit sum so there is no wrap. On overlapping regions the lowest index wins.
- IDLE, m_req=1: latch addr, we, wdata and the selected index into registers.
  - Any hit -> ACCESS.
  - No hit -> ERR.
- ACCESS:
  - s_sel[idx]=1, s_addr=latched addr-BASE_idx, s_we=latched we, s_wdata=latched wdata; all driven from registers and stable for the whole state.
  - The counter increments every ACCESS cycle.
  - s_ready[idx]=1 -> capture s_rdata slice (writes capture 0) -> RESP. The slave commits a write in its s_ready cycle.
  - Counter reaches TIMEOUT_CYCLES with TIMEOUT_CYCLES!=0 and no ready -> ERR. s_ready wins if both occur in the same cycle.
  - s_ready of non-selected slaves is ignored.
- RESP: m_ready=1, m_err=0, m_rdata=captured, for exactly one cycle -> IDLE.
- ERR: m_ready=1, m_err=1, m_rdata=0, for one cycle; err_valid<=1, err_addr<=latched addr -> IDLE.
- Outside RESP/ERR: m_ready=0, m_err=0, m_rdata=0. Outside ACCESS: s_sel=0, s_we=0.
- Latency:
  - Zero-wait slave (s_ready tied 1): request at edge N, m_ready visible after edge N+2.
  - Unmapped address: m_ready visible after edge N+1.
- Master protocol: m_req held high after m_ready is treated as a new request at the following IDLE cycle. Master inputs may change freely after acceptance.
- Error register: err_clear=1 clears err_valid. A new error in the same cycle wins (err_valid stays 1, err_addr updates). err_addr is not cleared by err_clear.

Decomposition:
- Shared defines (arch_defines): state encodings (BUS_IDLE/ACCESS/RESP/ERR), default ROM/RAM base and size constants feeding SLAVE_BASE/SLAVE_SIZE.
- Sub-module addr_region_match (parameters BASE, SIZE, ADDR_W; in addr; out hit). Instanced once per slave via generate; the priority encoder stays in the top.

Test Plan:
- Read slave 0, s_ready tied 1, m_addr=0x0000_0010, s_rdata0=0xA5:
  - s_sel=2'b01 and s_addr=0x10 one cycle after the request
  - m_ready=1, m_rdata=0xA5, m_err=0 two cycles after the request
- Write slave 1, m_addr=0x0000_1004, m_wdata=0x3C, s_ready1 delayed 3 cycles:
  - s_sel=2'b10, s_addr=0x004, s_we=1, s_wdata=0x3C held for 3 ACCESS cycles
  - m_ready pulses exactly once
- Unmapped m_addr=0x0000_2000 (first address past slave 1):
  - next cycle m_ready=1, m_err=1, m_rdata=0, s_sel never asserted
  - err_valid=1, err_addr=0x0000_2000
- Timeout, TIMEOUT_CYCLES=4, slave 1 never ready:
  - ERR after 4 ACCESS cycles, m_err=1
  - err_addr=request address
  - err_clear on that same cycle -> err_valid stays 1
- Reset asserted in the 2nd ACCESS cycle:
  - at that edge s_sel=0, state IDLE, no m_ready
  - a subsequent read to 0x0000_0000 completes normally
- Back-to-back: m_req held high across two reads (0x0001, then 0x1001):
  - two m_ready pulses 3 cycles apart
  - correct s_sel for each read

Source files
------------

// File: rtl/mem_bus_interconnect_pkg.sv
// +------------------------------------------------------------------+
// | mem_bus_interconnect_pkg                                          |
// | Shared state encodings and default ROM/RAM region map.            |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package mem_bus_interconnect_pkg;

   typedef enum logic [1:0] {
      BUS_IDLE   = 2'd0,
      BUS_ACCESS = 2'd1,
      BUS_RESP   = 2'd2,
      BUS_ERR    = 2'd3
   } bus_state_t;

   localparam logic [31:0] c_rom_base = 32'h0000_0000;
   localparam logic [31:0] c_rom_size = 32'h0000_1000;
   localparam logic [31:0] c_ram_base = 32'h0000_1000;
   localparam logic [31:0] c_ram_size = 32'h0000_1000;

   // Slave 0 occupies the low word, so ROM is the highest-priority target.
   localparam logic [63:0] c_default_base = {c_ram_base, c_rom_base};
   localparam logic [63:0] c_default_size = {c_ram_size, c_rom_size};

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_interconnect_if.sv
// +------------------------------------------------------------------+
// | mem_bus_interconnect_if                                           |
// | CPU-side request bus, slave-side select bus and error status.     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

interface mem_bus_interconnect_if #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 8,
   parameter int NUM_SLAVES = 2
);
   logic                         m_req;
   logic                         m_we;
   logic [ADDR_W-1:0]            m_addr;
   logic [DATA_W-1:0]            m_wdata;
   logic [DATA_W-1:0]            m_rdata;
   logic                         m_ready;
   logic                         m_err;
   logic [NUM_SLAVES-1:0]        s_sel;
   logic                         s_we;
   logic [ADDR_W-1:0]            s_addr;
   logic [DATA_W-1:0]            s_wdata;
   logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
   logic [NUM_SLAVES-1:0]        s_ready;
   logic                         err_valid;
   logic [ADDR_W-1:0]            err_addr;
   logic                         err_clear;

   // Environment view: CPU requests plus the memories' responses.
   modport master (
      output m_req, m_we, m_addr, m_wdata, err_clear, s_rdata, s_ready,
      input  m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata, err_valid, err_addr
   );

   modport slave (
      input  m_req, m_we, m_addr, m_wdata, err_clear, s_rdata, s_ready,
      output m_rdata, m_ready, m_err, s_sel, s_we, s_addr, s_wdata, err_valid, err_addr
   );

endinterface

`default_nettype wire

// File: rtl/mem_bus_interconnect_addr_region_match.sv
// +------------------------------------------------------------------+
// | addr_region_match                                                 |
// | Flags an address inside [BASE, BASE+SIZE) without wrap-around.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module addr_region_match #(
   parameter int                ADDR_W = 32,
   parameter logic [ADDR_W-1:0] BASE   = '0,
   parameter logic [ADDR_W-1:0] SIZE   = '0
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              hit
);

   localparam logic [ADDR_W:0] c_base = {1'b0, BASE};
   localparam logic [ADDR_W:0] c_size = {1'b0, SIZE};

   logic [ADDR_W:0] w_off;

   // Below-base addresses borrow into the extra MSB and so never compare below SIZE.
   assign w_off = {1'b0, addr} - c_base;
   assign hit   = (w_off < c_size);

endmodule

`default_nettype wire

// File: rtl/mem_bus_interconnect.sv
// +------------------------------------------------------------------+
// | mem_bus_interconnect                                              |
// | Registered CPU-to-NUM_SLAVES byte-bus router with bus errors.     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module mem_bus_interconnect
   import mem_bus_interconnect_pkg::*;
#(
   parameter int                           ADDR_W         = 32,
   parameter int                           DATA_W         = 8,
   parameter int                           NUM_SLAVES     = 2,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE     = c_default_base,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_SIZE     = c_default_size,
   parameter int                           TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_bus_interconnect_if.slave bus
);

   localparam int IDX_W = clog2_min1(NUM_SLAVES);
   localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W:0] c_timeout = (CNT_W+1)'(TIMEOUT_CYCLES);

   bus_state_t        r_state;
   bus_state_t        w_state_next;
   logic [NUM_SLAVES-1:0] w_hit;
   logic [IDX_W-1:0]  w_idx;
   logic [ADDR_W-1:0] w_off;
   logic              w_sel_ready;
   logic [DATA_W-1:0] w_sel_rdata;
   logic [CNT_W:0]    w_cnt_inc;
   logic              w_timeout;

   logic [IDX_W-1:0]  r_idx;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_off;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_err_valid;
   logic [ADDR_W-1:0] r_err_addr;

   generate
      for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
         addr_region_match #(
            .ADDR_W (ADDR_W),
            .BASE   (SLAVE_BASE[gi*ADDR_W +: ADDR_W]),
            .SIZE   (SLAVE_SIZE[gi*ADDR_W +: ADDR_W])
         ) u_match (
            .addr (bus.m_addr),
            .hit  (w_hit[gi])
         );
      end
   endgenerate

   // Descending scan so the lowest matching index is the last assignment.
   always_comb begin
      w_idx = '0;
      w_off = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_idx = IDX_W'(i);
            w_off = bus.m_addr - SLAVE_BASE[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_comb begin
      w_sel_ready = 1'b0;
      w_sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_sel_ready = bus.s_ready[i];
            w_sel_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == c_timeout);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= BUS_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      bus.m_ready  = 1'b0;
      bus.m_err    = 1'b0;
      bus.m_rdata  = '0;
      bus.s_sel    = '0;
      bus.s_we     = 1'b0;
      bus.s_addr   = '0;
      bus.s_wdata  = '0;
      case (r_state)
         BUS_IDLE: begin
            if (bus.m_req) begin
               w_state_next = (|w_hit) ? BUS_ACCESS : BUS_ERR;
            end
         end
         BUS_ACCESS: begin
            bus.s_sel   = NUM_SLAVES'(1) << r_idx;
            bus.s_we    = r_we;
            bus.s_addr  = r_off;
            bus.s_wdata = r_wdata;
            // A ready arriving on the timeout cycle still completes normally.
            if (w_sel_ready) begin
               w_state_next = BUS_RESP;
            end else if (w_timeout) begin
               w_state_next = BUS_ERR;
            end
         end
         BUS_RESP: begin
            bus.m_ready  = 1'b1;
            bus.m_rdata  = r_rdata;
            w_state_next = BUS_IDLE;
         end
         BUS_ERR: begin
            bus.m_ready  = 1'b1;
            bus.m_err    = 1'b1;
            w_state_next = BUS_IDLE;
         end
         default: begin
            w_state_next = BUS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx       <= '0;
         r_addr      <= '0;
         r_off       <= '0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_cnt       <= '0;
         r_err_valid <= 1'b0;
         r_err_addr  <= '0;
      end else begin
         if ((r_state == BUS_IDLE) && bus.m_req) begin
            r_idx   <= w_idx;
            r_addr  <= bus.m_addr;
            r_off   <= w_off;
            r_we    <= bus.m_we;
            r_wdata <= bus.m_wdata;
            r_cnt   <= '0;
         end
         if (r_state == BUS_ACCESS) begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
            if (w_sel_ready) begin
               r_rdata <= r_we ? '0 : w_sel_rdata;
            end
         end
         // Raising a new error takes precedence over a same-cycle clear.
         if (r_state == BUS_ERR) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= r_addr;
         end else if (bus.err_clear) begin
            r_err_valid <= 1'b0;
         end
      end
   end

   assign bus.err_valid = r_err_valid;
   assign bus.err_addr  = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_interconnect.sv
// +------------------------------------------------------------------+
// | tb_mem_bus_interconnect                                           |
// | Directed scoreboard bench for mem_bus_interconnect.               |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mem_bus_interconnect;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_bus_interconnect_if #(.ADDR_W(32), .DATA_W(8), .NUM_SLAVES(2)) bus ();

   mem_bus_interconnect #(
      .ADDR_W         (32),
      .DATA_W         (8),
      .NUM_SLAVES     (2),
      .SLAVE_BASE     ({32'h0000_1000, 32'h0000_0000}),
      .SLAVE_SIZE     ({32'h0000_1000, 32'h0000_1000}),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [8:0] exp_q[$];   // {m_err, m_rdata}
   int pulse_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Response monitor: every m_ready pulse must match the oldest expected response.
   always @(negedge clk) begin : mon
      logic [8:0] e;
      if (bus.m_ready === 1'b1) begin
         pulse_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: got m_ready=1 with err=%b rdata=%h, expected no pulse",
                     bus.m_err, bus.m_rdata);
         end else begin
            e = exp_q.pop_front();
            chk("resp_err", {31'd0, bus.m_err}, {31'd0, e[8]});
            chk("resp_rdata", {24'd0, bus.m_rdata}, {24'd0, e[7:0]});
         end
      end else if (bus.m_err !== 1'b0) begin
         chk("err_without_ready", {31'd0, bus.m_err}, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.m_req     = 1'b0;
      bus.m_we      = 1'b0;
      bus.m_addr    = '0;
      bus.m_wdata   = '0;
      bus.s_rdata   = '0;
      bus.s_ready   = '0;
      bus.err_clear = 1'b0;
      rst = 1'b1;
      step;
      step;
      @(negedge clk);
      chk("rst_ready", {31'd0, bus.m_ready}, 32'd0);
      chk("rst_sel", {30'd0, bus.s_sel}, 32'd0);
      chk("rst_err_valid", {31'd0, bus.err_valid}, 32'd0);
      chk("rst_err_addr", bus.err_addr, 32'd0);
      step;
      rst = 1'b0;

      // Read slave 0, zero-wait.
      bus.s_ready = 2'b11;
      bus.s_rdata = 16'h00A5;
      bus.m_addr  = 32'h0000_0010;
      bus.m_req   = 1'b1;
      exp_q.push_back({1'b0, 8'hA5});
      step;
      bus.m_req  = 1'b0;
      bus.m_addr = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("t1_sel", {30'd0, bus.s_sel}, 32'h1);
      chk("t1_saddr", bus.s_addr, 32'h10);
      chk("t1_swe", {31'd0, bus.s_we}, 32'd0);
      step;
      step;

      // Write slave 1, ready delayed; slave 0 ready is ignored.
      bus.s_ready = 2'b01;
      bus.s_rdata = 16'h7700;
      bus.m_we    = 1'b1;
      bus.m_addr  = 32'h0000_1004;
      bus.m_wdata = 8'h3C;
      bus.m_req   = 1'b1;
      exp_q.push_back({1'b0, 8'h00});
      step;
      bus.m_req   = 1'b0;
      bus.m_we    = 1'b0;
      bus.m_addr  = 32'h0;
      bus.m_wdata = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t2_sel", {30'd0, bus.s_sel}, 32'h2);
         chk("t2_saddr", bus.s_addr, 32'h4);
         chk("t2_swe", {31'd0, bus.s_we}, 32'd1);
         chk("t2_swdata", {24'd0, bus.s_wdata}, 32'h3C);
         step;
      end
      bus.s_ready = 2'b11;
      @(negedge clk);
      chk("t2_sel_last", {30'd0, bus.s_sel}, 32'h2);
      step;
      bus.s_ready = 2'b00;
      step;
      @(negedge clk);
      chk("t2_idle_sel", {30'd0, bus.s_sel}, 32'd0);
      chk("t2_idle_swe", {31'd0, bus.s_we}, 32'd0);

      // Unmapped address just past slave 1.
      bus.m_addr = 32'h0000_2000;
      bus.m_req  = 1'b1;
      exp_q.push_back({1'b1, 8'h00});
      step;
      bus.m_req = 1'b0;
      @(negedge clk);
      chk("t3_sel", {30'd0, bus.s_sel}, 32'd0);
      step;
      @(negedge clk);
      chk("t3_err_valid", {31'd0, bus.err_valid}, 32'd1);
      chk("t3_err_addr", bus.err_addr, 32'h0000_2000);
      bus.err_clear = 1'b1;
      step;
      bus.err_clear = 1'b0;
      @(negedge clk);
      chk("t3_clr_valid", {31'd0, bus.err_valid}, 32'd0);
      chk("t3_clr_addr", bus.err_addr, 32'h0000_2000);

      // Timeout on slave 1 with a clear in the error cycle.
      bus.s_ready = 2'b01;
      bus.m_addr  = 32'h0000_1008;
      bus.m_req   = 1'b1;
      exp_q.push_back({1'b1, 8'h00});
      step;
      bus.m_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t4_sel", {30'd0, bus.s_sel}, 32'h2);
         step;
      end
      bus.err_clear = 1'b1;
      @(negedge clk);
      chk("t4_err_sel", {30'd0, bus.s_sel}, 32'd0);
      step;
      bus.err_clear = 1'b0;
      @(negedge clk);
      chk("t4_err_valid", {31'd0, bus.err_valid}, 32'd1);
      chk("t4_err_addr", bus.err_addr, 32'h0000_1008);

      // Reset during the second access cycle.
      bus.s_ready = 2'b00;
      bus.m_addr  = 32'h0000_1000;
      bus.m_req   = 1'b1;
      step;
      bus.m_req = 1'b0;
      step;
      rst = 1'b1;
      @(negedge clk);
      chk("t5_sel_pre", {30'd0, bus.s_sel}, 32'h2);
      step;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_sel_post", {30'd0, bus.s_sel}, 32'd0);
      chk("t5_err_valid", {31'd0, bus.err_valid}, 32'd0);
      chk("t5_err_addr", bus.err_addr, 32'd0);
      step;
      step;
      bus.s_ready = 2'b01;
      bus.s_rdata = 16'h005A;
      bus.m_addr  = 32'h0000_0000;
      bus.m_req   = 1'b1;
      exp_q.push_back({1'b0, 8'h5A});
      step;
      bus.m_req = 1'b0;
      @(negedge clk);
      chk("t5_sel_read", {30'd0, bus.s_sel}, 32'h1);
      chk("t5_saddr", bus.s_addr, 32'h0);
      step;
      step;

      // Back-to-back reads with m_req held high.
      @(negedge clk);
      pulse_cyc.delete();
      bus.s_ready = 2'b11;
      bus.s_rdata = 16'hC37E;
      bus.m_addr  = 32'h0000_0001;
      bus.m_req   = 1'b1;
      exp_q.push_back({1'b0, 8'h7E});
      exp_q.push_back({1'b0, 8'hC3});
      step;
      bus.m_addr = 32'h0000_1001;
      @(negedge clk);
      chk("t6_sel_a", {30'd0, bus.s_sel}, 32'h1);
      chk("t6_saddr_a", bus.s_addr, 32'h1);
      step;
      step;
      step;
      bus.m_req = 1'b0;
      @(negedge clk);
      chk("t6_sel_b", {30'd0, bus.s_sel}, 32'h2);
      chk("t6_saddr_b", bus.s_addr, 32'h1);
      step;
      step;
      step;
      @(negedge clk);
      chk("t6_pulses", pulse_cyc.size(), 32'd2);
      if (pulse_cyc.size() == 2) begin
         chk("t6_gap", pulse_cyc[1] - pulse_cyc[0], 32'd3);
      end

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
